// File: rtl/seq_mul_hs.sv
// Iterative shift-and-add multiplier (WIDTH x WIDTH -> 2*WIDTH) with valid/ready on both sides.
// Define SEQ_MUL_EARLY_TERM_EN for data-dependent latency; default build is constant-time.
module seq_mul_hs #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q, prod_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   partial_s, acc_sum_s;
    logic                 term_s;

    // Operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        if ((SIGNED != 0) && v[WIDTH-1]) begin
            mag_f = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_f = v;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_f(input logic [2*WIDTH-1:0] v);
        neg_f = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Partial product, running sum and loop termination for the current RUN cycle.
    always_comb begin
        partial_s = {(2*WIDTH){1'b0}};
        if (b_q[0]) begin
            partial_s = {{WIDTH{1'b0}}, a_q} << cnt_q;
        end else begin
            partial_s = {(2*WIDTH){1'b0}};
        end
        acc_sum_s = acc_q + partial_s;
`ifdef SEQ_MUL_EARLY_TERM_EN
        term_s = (b_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (cnt_q == CNT_W'(WIDTH-1));
`else
        term_s = (cnt_q == CNT_W'(WIDTH-1));
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            S_RUN: begin
                if (term_s) state_d = S_DONE;
                else        state_d = S_RUN;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
                else           state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode; product is registered on the terminating edge so it is stable in DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out_prod  = prod_q;
        case (state_q)
            S_IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
            S_RUN:   begin in_ready = 1'b0; busy = 1'b1; end
            S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
            default: begin in_ready = 1'b0; busy = 1'b1; end
        endcase
    end

    // Datapath: latch operands on accept, then retire one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            acc_q  <= {(2*WIDTH){1'b0}};
            prod_q <= {(2*WIDTH){1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            neg_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= mag_f(a);
                        b_q   <= mag_f(b);
                        neg_q <= (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                        acc_q <= {(2*WIDTH){1'b0}};
                        cnt_q <= {CNT_W{1'b0}};
                    end
                end
                S_RUN: begin
                    acc_q <= acc_sum_s;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (term_s) begin
                        prod_q <= neg_q ? neg_f(acc_sum_s) : acc_sum_s;
                    end
                end
                default: begin
                    prod_q <= prod_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_hs.sv
// Self-checking bench for seq_mul_hs: directed table, stall/reset sequences, random ops
// against an arithmetic reference, and a twin instance for timing-equivalence of out_valid.
module tb_seq_mul_hs;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, out_ready, in_ready, out_valid, busy;
    logic [W-1:0] a, b, a_t;
    logic [2*W-1:0] out_prod;
    logic         t_in_ready, t_out_valid, t_busy;
    logic [2*W-1:0] t_out_prod;
    logic         s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_busy;
    logic [W-1:0] s_a, s_b;
    logic [2*W-1:0] s_out_prod;

    int n_vec = 0;
    int n_err = 0;

    seq_mul_hs #(.WIDTH(W), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .busy(busy));

    seq_mul_hs #(.WIDTH(W), .SIGNED(0)) u_twin (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .a(a_t), .b(b), .out_valid(t_out_valid), .out_ready(out_ready),
        .out_prod(t_out_prod), .busy(t_busy));

    seq_mul_hs #(.WIDTH(W), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_prod(s_out_prod), .busy(s_busy));

    typedef struct {
        int           sel;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] prod_model(input int sel, input logic [W-1:0] av,
                                                   input logic [W-1:0] bv);
        int sa, sb;
        if (sel == 1) begin
            sa = $signed(av);
            sb = $signed(bv);
        end else begin
            sa = int'(av);
            sb = int'(bv);
        end
        return 16'(sa * sb);
    endfunction

    function automatic int lat_model(input int sel, input logic [W-1:0] bv);
        int m;
        m = (sel == 1) ? ($signed(bv) < 0 ? -int'($signed(bv)) : int'($signed(bv))) : int'(bv);
`ifdef SEQ_MUL_EARLY_TERM_EN
        if (m == 0) return 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (m >= (1 << i)) return i + 1;
        end
        return 1;
`else
        return W + (m & 0);
`endif
    endfunction

    task automatic issue(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] at);
        int guard;
        guard = 0;
        while (((sel == 1) ? s_in_ready : in_ready) !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        if (sel == 1) begin
            s_in_valid = 1'b1; s_a = av; s_b = bv;
        end else begin
            in_valid = 1'b1; a = av; b = bv; a_t = at;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; s_in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); a_t = W'($urandom);
        s_a = W'($urandom); s_b = W'($urandom);
    endtask

    task automatic wait_done(input int sel, output int lat, output logic wave_ok);
        lat = 0;
        wave_ok = 1'b1;
        while (((sel == 1) ? s_out_valid : out_valid) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (sel == 0 && out_valid !== t_out_valid) wave_ok = 1'b0;
        end
        if (lat >= 40) begin
            n_err++;
            $display("FAIL done_timeout: out_valid never rose");
        end
    endtask

    task automatic retire(input int sel);
        if (sel == 1) s_out_ready = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0; out_ready = 1'b0;
        chk("in_ready_after_hs", (sel == 1) ? s_in_ready : in_ready, 1);
    endtask

    task automatic run_vec(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp, input string name);
        int lat;
        logic wave_ok;
        logic [W-1:0] at;
        at = W'($urandom);
        issue(sel, av, bv, at);
        wait_done(sel, lat, wave_ok);
        chk({name, "_lat"}, lat, lat_model(sel, bv));
        chk({name, "_prod"}, (sel == 1) ? s_out_prod : out_prod, exp);
        if (sel == 0) begin
            chk({name, "_twin_prod"}, t_out_prod, prod_model(0, at, bv));
            chk({name, "_twin_wave"}, wave_ok, 1);
        end
        retire(sel);
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic stable;
        logic [W-1:0] ra, rb;
        int lat;
        logic wave_ok;

        tbl[0] = '{0, 8'd13,  8'd11,  16'h008F};
        tbl[1] = '{0, 8'd200, 8'd3,   16'd600};
        tbl[2] = '{0, 8'd1,   8'h80,  16'd128};
        tbl[3] = '{0, 8'd55,  8'd0,   16'd0};
        tbl[4] = '{0, 8'd255, 8'd255, 16'hFE01};
        tbl[5] = '{1, 8'h80,  8'h80,  16'h4000};
        tbl[6] = '{1, 8'hFD,  8'h05,  16'hFFF1};
        tbl[7] = '{1, 8'hFF,  8'hFF,  16'h0001};
        tbl[8] = '{1, 8'h7F,  8'h80,  16'hC080};
        tbl[9] = '{1, 8'h00,  8'h93,  16'h0000};

        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; a_t = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_prod", out_prod, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i].sel, tbl[i].av, tbl[i].bv, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Stall in DONE with a stray in_valid pulse
        issue(0, 8'd21, 8'd6, 8'd3);
        wait_done(0, lat, wave_ok);
        p = out_prod;
        chk("stall_prod", p, 16'd126);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 4);
            a = 8'd99; b = 8'd77;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_prod !== p || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("stall_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_hs_out_valid", out_valid, 0);
        chk("stall_hs_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("stall_no_hidden_accept", busy, 0);

        // Async reset in the middle of RUN
        issue(0, 8'd100, 8'd200, 8'd5);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_prod", out_prod, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0, 8'd7, 8'd9, 16'd63, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            if (i % 16 == 0) rb = 8'h00;
            run_vec(0, ra, rb, prod_model(0, ra, rb), "rnd_u");
        end
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            if (i % 20 == 0) ra = 8'h80;
            run_vec(1, ra, rb, prod_model(1, ra, rb), "rnd_s");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
